// File: rtl/mutex_client.sv
// mutex_client: local client of an asynchronous four-phase mutex element.
// A local acquire raises req towards the mutex, waits for the synchronised grant
// (with an optional timeout), holds ownership for a programmed number of cycles
// or until released, then drops req and waits for the grant to return to zero.
//
// Ports:
//   clk, rst_n      single clock, synchronous active-low reset
//   acq_req         acquire request (sampled only when idle)
//   acq_hold        ownership cycles captured with acq_req; 0 = hold until rel
//   rel             local release (honoured only while owning)
//   tmo_lim         grant-wait limit in cycles; 0 disables the timeout
//   req             registered request to the mutex r input
//   gnt             asynchronous grant from the mutex g output
//   owned           high while owning the mutex
//   busy            high whenever not idle
//   done            one-cycle pulse on normal completion
//   tmo             one-cycle pulse on timeout-abort completion
//   err             sticky protocol-violation flag
module mutex_client #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_W      = 8,
  parameter int unsigned TMO_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acq_req,
  input  logic [HOLD_W-1:0] acq_hold,
  input  logic              rel,
  input  logic [TMO_W-1:0]  tmo_lim,
  output logic              req,
  input  logic              gnt,
  output logic              owned,
  output logic              busy,
  output logic              done,
  output logic              tmo,
  output logic              err
);

  typedef enum logic [2:0] {StIdle, StReq, StOwn, StRel, StAbort} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   gnt_s;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [TMO_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                   done_d, tmo_d, err_d;
  logic                   req_q, owned_q, busy_q, done_q, tmo_q, err_q;

  // Only the synchroniser chain touches the asynchronous grant.
  assign gnt_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    wait_cnt_d = wait_cnt_q;
    done_d     = 1'b0;
    tmo_d      = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        // A grant while we are not requesting means the mutex is misbehaving.
        if (gnt_s) err_d = 1'b1;
        if (acq_req) begin
          hold_cnt_d = acq_hold;
          wait_cnt_d = '0;
          state_d    = StReq;
        end
      end
      StReq: begin
        // A grant wins over a timeout that expires in the same cycle.
        if (gnt_s) begin
          state_d = StOwn;
        end else begin
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + TMO_W'(1);
          if ((tmo_lim != '0) && (wait_cnt_q == tmo_lim)) state_d = StAbort;
        end
      end
      StOwn: begin
        // hold_cnt only reaches zero here when the captured hold was zero,
        // since a finite hold leaves OWN as the count steps from one to zero.
        if (!gnt_s) begin
          err_d   = 1'b1;
          state_d = StRel;
        end else if (rel) begin
          state_d = StRel;
        end else if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          if (hold_cnt_q == HOLD_W'(1)) state_d = StRel;
        end
      end
      StRel: begin
        if (!gnt_s) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StAbort: begin
        if (!gnt_s) begin
          state_d = StIdle;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
      req_q      <= 1'b0;
      owned_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], gnt};
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      // Outputs decoded from next state so they are plain flops, glitch-free.
      req_q      <= (state_d == StReq) || (state_d == StOwn);
      owned_q    <= (state_d == StOwn);
      busy_q     <= (state_d != StIdle);
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
    end
  end

  assign req   = req_q;
  assign owned = owned_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign tmo   = tmo_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mutex_client.sv
// tb_mutex_client: scoreboard bench for mutex_client. Two clients share a
// behavioural mutex model; client A can alternatively have its grant driven
// directly. Expected owned edges, done and tmo pulses of client A are queued
// with their cycle numbers when stimulus is applied and compared as they occur.
module tb_mutex_client;

  localparam int SS = 2;
  localparam int HW = 8;
  localparam int TW = 16;

  localparam int EvRise = 1;
  localparam int EvFall = 2;
  localparam int EvDone = 3;
  localparam int EvTmo  = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          acq_req_a, rel_a, acq_req_b;
  logic [HW-1:0] acq_hold_a, acq_hold_b;
  logic [TW-1:0] tmo_lim_a, tmo_lim_b;
  logic          req_a, owned_a, busy_a, done_a, tmo_a, err_a;
  logic          req_b, owned_b, busy_b, done_b, tmo_b, err_b;
  logic          gnt_a, gnt_b;
  logic          use_model, drv_a, mx_a, mx_b;
  logic          rel_b;

  int  cyc = 0;
  int  mx_dly = 3;
  int  n_checks = 0;
  int  n_pass = 0;
  int  done_b_cnt = 0;
  int  both_cnt = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];

  assign gnt_a = use_model ? mx_a : drv_a;
  assign gnt_b = use_model ? mx_b : 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  mutex_client #(.SYNC_STAGES(SS), .HOLD_W(HW), .TMO_W(TW)) u_a (
    .clk(clk), .rst_n(rst_n), .acq_req(acq_req_a), .acq_hold(acq_hold_a), .rel(rel_a),
    .tmo_lim(tmo_lim_a), .req(req_a), .gnt(gnt_a), .owned(owned_a), .busy(busy_a),
    .done(done_a), .tmo(tmo_a), .err(err_a)
  );

  mutex_client #(.SYNC_STAGES(SS), .HOLD_W(HW), .TMO_W(TW)) u_b (
    .clk(clk), .rst_n(rst_n), .acq_req(acq_req_b), .acq_hold(acq_hold_b), .rel(rel_b),
    .tmo_lim(tmo_lim_b), .req(req_b), .gnt(gnt_b), .owned(owned_b), .busy(busy_b),
    .done(done_b), .tmo(tmo_b), .err(err_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic expect_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e.kind = 0;
      e.cyc  = -1;
    end
    check("ev_kind", kind, e.kind);
    check("ev_cycle", cyc, e.cyc);
  endtask

  // Mutex model: grants after mx_dly negedges of request, releases as soon as
  // the request is seen low; client A wins a tie.
  int cnt_a = 0;
  int cnt_b = 0;
  initial begin
    mx_a = 1'b0;
    mx_b = 1'b0;
    forever begin
      @(negedge clk);
      if (mx_a && !req_a) mx_a = 1'b0;
      if (mx_b && !req_b) mx_b = 1'b0;
      if (!req_a) cnt_a = 0;
      if (!req_b) cnt_b = 0;
      if (!use_model) begin
        mx_a = 1'b0;
        mx_b = 1'b0;
      end else if (!mx_a && !mx_b) begin
        if (req_a) cnt_a = cnt_a + 1;
        if (req_b) cnt_b = cnt_b + 1;
        if (req_a && cnt_a >= mx_dly) mx_a = 1'b1;
        else if (req_b && cnt_b >= mx_dly) mx_b = 1'b1;
      end
    end
  end

  // Monitor for client A events and cross-client exclusion.
  initial begin
    logic prev_owned;
    prev_owned = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (owned_a != prev_owned) observe(owned_a ? EvRise : EvFall);
        if (done_a) observe(EvDone);
        if (tmo_a) observe(EvTmo);
        prev_owned = owned_a;
        if (done_b) done_b_cnt++;
        if (owned_a && owned_b) both_cnt++;
      end
    end
  end

  task automatic go(input int x);
    while (cyc < x) @(negedge clk);
  endtask

  // Called at a negedge; returns at the next negedge, where cyc == r0.
  task automatic start_a(input int hold, input int lim, output int r0);
    acq_hold_a = HW'(hold);
    tmo_lim_a  = TW'(lim);
    acq_req_a  = 1'b1;
    r0         = cyc + 1;
    @(negedge clk);
    acq_req_a  = 1'b0;
  endtask

  task automatic finish_test(input int limit);
    int k = 0;
    while ((busy_a || busy_b) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", int'(busy_a | busy_b), 0);
    repeat (2) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int r0, rise, x, c;
    rst_n = 1'b0; acq_req_a = 1'b0; rel_a = 1'b0; acq_req_b = 1'b0; rel_b = 1'b0;
    acq_hold_a = '0; acq_hold_b = '0; tmo_lim_a = '0; tmo_lim_b = '0;
    use_model = 1'b0; drv_a = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", int'(req_a), 0);
    check("rst_owned", int'(owned_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_tmo", int'(tmo_a), 0);
    check("rst_err", int'(err_a), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Basic acquire, hold 5; stray rel in IDLE and acq_req in OWN are ignored.
    use_model = 1'b1;
    rel_a = 1'b1;
    start_a(5, 0, r0);
    rel_a = 1'b0;
    rise = r0 + mx_dly + SS;
    expect_ev(EvRise, rise);
    expect_ev(EvFall, rise + 5);
    expect_ev(EvDone, rise + 5 + SS + 1);
    go(rise + 1);
    acq_hold_a = HW'(1);
    acq_req_a  = 1'b1;
    @(negedge clk);
    acq_req_a  = 1'b0;
    finish_test(100);
    check("basic_req_low", int'(req_a), 0);

    // Hold until release, rel in the 20th owned cycle.
    start_a(0, 0, r0);
    rise = r0 + mx_dly + SS;
    expect_ev(EvRise, rise);
    go(rise + 19);
    rel_a = 1'b1;
    expect_ev(EvFall, rise + 20);
    expect_ev(EvDone, rise + 20 + SS + 1);
    @(negedge clk);
    rel_a = 1'b0;
    finish_test(100);

    // Timeout with grant held low.
    use_model = 1'b0;
    drv_a = 1'b0;
    start_a(5, 10, r0);
    go(r0 + 10);
    check("tmo_req_high", int'(req_a), 1);
    @(negedge clk);
    check("tmo_req_low", int'(req_a), 0);
    check("tmo_busy_abort", int'(busy_a), 1);
    expect_ev(EvTmo, r0 + 12);
    finish_test(100);
    check("tmo_err", int'(err_a), 0);

    // Grant synchronises one cycle too late: abort, then wait for gnt to drop.
    start_a(5, 10, r0);
    go(r0 + 9);
    drv_a = 1'b1;
    go(r0 + 11);
    check("late_req_low", int'(req_a), 0);
    drv_a = 1'b0;
    expect_ev(EvTmo, r0 + 14);
    finish_test(100);

    // Grant synchronises in the cycle the timeout is met: grant wins.
    start_a(3, 10, r0);
    go(r0 + 8);
    drv_a = 1'b1;
    rise = r0 + 11;
    expect_ev(EvRise, rise);
    expect_ev(EvFall, rise + 3);
    expect_ev(EvDone, rise + 3 + SS + 1);
    go(rise + 3);
    drv_a = 1'b0;
    finish_test(100);

    // Grant falls while owning: err, release, done still pulses.
    start_a(0, 0, r0);
    drv_a = 1'b1;
    rise = r0 + 1 + SS;
    expect_ev(EvRise, rise);
    go(rise + 4);
    x = rise + 4;
    drv_a = 1'b0;
    expect_ev(EvFall, x + 3);
    expect_ev(EvDone, x + 4);
    finish_test(100);
    check("gnt_fall_err", int'(err_a), 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("err_cleared", int'(err_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Grant in IDLE sets err, which then stays set.
    c = cyc;
    drv_a = 1'b1;
    go(c + 2);
    check("idle_err_before", int'(err_a), 0);
    @(negedge clk);
    check("idle_err_set", int'(err_a), 1);
    drv_a = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_err_sticky", int'(err_a), 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while owning: req drops at that edge, no done.
    use_model = 1'b1;
    start_a(0, 0, r0);
    rise = r0 + mx_dly + SS;
    expect_ev(EvRise, rise);
    go(rise + 2);
    rst_n = 1'b0;
    expect_ev(EvFall, rise + 3);
    @(negedge clk);
    check("rst_own_req", int'(req_a), 0);
    check("rst_own_err", int'(err_a), 0);
    check("rst_own_busy", int'(busy_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_own_err_after", int'(err_a), 0);
    finish_test(100);

    // Two clients contend on one mutex; A wins the tie.
    done_b_cnt = 0;
    both_cnt   = 0;
    acq_hold_a = HW'(4);
    acq_hold_b = HW'(6);
    tmo_lim_a  = '0;
    tmo_lim_b  = '0;
    acq_req_a  = 1'b1;
    acq_req_b  = 1'b1;
    r0 = cyc + 1;
    rise = r0 + mx_dly + SS;
    expect_ev(EvRise, rise);
    expect_ev(EvFall, rise + 4);
    expect_ev(EvDone, rise + 4 + SS + 1);
    @(negedge clk);
    acq_req_a = 1'b0;
    acq_req_b = 1'b0;
    finish_test(300);
    check("b_done_count", done_b_cnt, 1);
    check("both_owned_cycles", both_cnt, 0);
    check("b_tmo", int'(tmo_b), 0);
    check("b_err", int'(err_b), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mutex_client.md
MUTEX_CLIENT -- requirements
Module: mutex_client

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on gnt (legal values 2..4).
REQ-002 SHALL have parameter HOLD_W, default 8, meaning the width of the ownership hold counter.
REQ-003 SHALL have parameter TMO_W, default 16, meaning the width of the grant-wait timeout counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port acq_req, input, 1 bit: local acquire request, sampled only in IDLE.
REQ-007 SHALL have port acq_hold, input, HOLD_W bits: ownership cycles, captured with acq_req; 0 means hold until rel.
REQ-008 SHALL have port rel, input, 1 bit: local release, honoured only in OWN.
REQ-009 SHALL have port tmo_lim, input, TMO_W bits: grant-wait limit in cycles; 0 disables the timeout.
REQ-010 SHALL have port req, output, 1 bit: four-phase request to a mutex r input; registered, glitch-free.
REQ-011 SHALL have port gnt, input, 1 bit: asynchronous grant from the mutex g output.
REQ-012 SHALL have port owned, output, 1 bit: high exactly while the state is OWN.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-015 SHALL have port tmo, output, 1 bit: one-cycle pulse on timeout-abort completion.
REQ-016 SHALL have port err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-017 SHALL pass gnt through a SYNC_STAGES-deep flop chain; gnt_s is the last stage, and no logic other than the chain SHALL read gnt.
REQ-018 SHALL implement states IDLE, REQ, OWN, REL and ABORT, with req = 1 exactly in REQ and OWN.
REQ-019 In IDLE with acq_req = 1, SHALL capture acq_hold into hold_cnt, clear wait_cnt and enter REQ; req SHALL rise at that edge.
REQ-020 In REQ with gnt_s = 1, SHALL enter OWN; owned SHALL rise SYNC_STAGES edges after the edge that first samples gnt high.
REQ-021 In REQ with gnt_s = 0, SHALL increment wait_cnt (saturating); when tmo_lim != 0 and wait_cnt == tmo_lim, SHALL enter ABORT.
REQ-022 If gnt_s = 1 in the same cycle the timeout condition is met, SHALL take the grant and enter OWN.
REQ-023 In OWN with captured hold != 0, SHALL decrement hold_cnt each cycle and enter REL after exactly hold cycles of owned = 1.
REQ-024 In OWN, rel = 1 SHALL enter REL at the next edge regardless of hold_cnt; with hold = 0, only rel exits OWN.
REQ-025 In REL and ABORT, req SHALL be 0; each state SHALL wait for gnt_s = 0, then enter IDLE.
REQ-026 On REL to IDLE, done SHALL pulse; on ABORT to IDLE, tmo SHALL pulse; the two SHALL never be high together.
REQ-027 acq_req outside IDLE and rel outside OWN SHALL be ignored, with no queuing.
REQ-028 gnt_s = 1 in IDLE SHALL set err.
REQ-029 gnt_s falling in OWN SHALL set err and enter REL; the eventual done SHALL still pulse.
REQ-030 A new acquisition SHALL NOT start until the state returns to IDLE, guaranteeing four-phase return-to-zero.

Reset
REQ-031 With rst_n = 0 at a rising edge, SHALL set state IDLE, clear the sync chain, clear hold_cnt and wait_cnt, and drive req, owned, busy, done, tmo and err to 0.
REQ-032 Reset mid-operation (REQ or OWN) SHALL drop req at that edge with no done or tmo pulse; the mutex releases the grant asynchronously.

Verification
REQ-033 Basic acquire: SYNC_STAGES = 2, acq_hold = 5, mutex model grants 3 cycles after req rises -> owned high for exactly 5 cycles, req low, done pulses once after gnt is low 2 cycles.
REQ-034 Hold until release: acq_hold = 0, rel at the 20th owned cycle -> owned high for 20 cycles, drops the edge after rel, then done.
REQ-035 Timeout: tmo_lim = 10, gnt held low -> req low after 10 wait cycles, tmo pulses, no done, busy low.
REQ-036 Grant/timeout race: gnt synchronizes in the same cycle wait_cnt == tmo_lim -> OWN is entered, no tmo pulse.
REQ-037 Two clients contending on one mutex model: both assert acq_req together -> owned is never high in both at once, both complete with done.
REQ-038 Violations and reset: gnt forced high in IDLE -> err = 1 and sticky; rst_n low during OWN -> req = 0 and err = 0 at the next edge.
